// File: rtl/bpu_resolve_queue.sv
// Branch-prediction resolve queue: tracks in-flight predicted-taken branches and
// checks them against Execute outcomes. Optional stats counters: BPU_RESOLVE_STATS_EN.
module bpu_resolve_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            pred_valid_i,
    input  logic [XLEN-1:0] pred_pc_i,
    input  logic [XLEN-1:0] pred_target_i,
    input  logic            exe_is_branch_i,
    input  logic [XLEN-1:0] exe_pc_i,
    input  logic            exe_taken_i,
    input  logic [XLEN-1:0] exe_target_i,
    output logic            full_o,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            upd_valid_o,
    output logic [XLEN-1:0] upd_pc_o,
    output logic            upd_taken_o,
    output logic [XLEN-1:0] upd_target_o,
`ifdef BPU_RESOLVE_STATS_EN
    output logic [31:0]     stat_resolved_o,
    output logic [31:0]     stat_mispredict_o,
    output logic [31:0]     stat_unpredicted_o,
`endif
    output logic            overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_mem  [DEPTH];
    logic [XLEN-1:0]  tgt_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic            empty;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_tgt;
    logic            resolve;
    logic            hit;
    logic            mis;
    logic            recover;
    logic            pop;
    logic            push_req;
    logic            push;
    logic            ovf_set;
    logic [XLEN-1:0] redirect;

    // Head comparison, push/pop arbitration and recovery decode
    always_comb begin
        empty    = (count_q == '0);
        full_o   = (count_q == CNT_W'(DEPTH));
        head_pc  = pc_mem[rd_ptr_q];
        head_tgt = tgt_mem[rd_ptr_q];
        resolve  = ~stall_i & exe_is_branch_i & ~flush_i;
        hit      = ~empty & (head_pc == exe_pc_i);
        mis      = (exe_taken_i != hit) | (exe_taken_i & hit & (exe_target_i != head_tgt));
        // A registered mispredict means every queued entry is wrong-path
        recover  = flush_i | mispredict_o;
        pop      = resolve & hit & ~recover;
        push_req = ~stall_i & pred_valid_i & ~recover;
        push     = push_req & (~full_o | pop);
        ovf_set  = push_req & full_o & ~pop;
        redirect = exe_taken_i ? exe_target_i : exe_pc_i + XLEN'(4);
    end

    // Entry storage; contents need no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= pred_pc_i;
            tgt_mem[wr_ptr_q] <= pred_target_i;
        end
    end

    // Pointers, occupancy and registered strobes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
            upd_valid_o   <= 1'b0;
            upd_pc_o      <= '0;
            upd_taken_o   <= 1'b0;
            upd_target_o  <= '0;
            overflow_o    <= 1'b0;
        end else begin
            mispredict_o <= resolve & mis;
            upd_valid_o  <= resolve;
            if (resolve) begin
                upd_pc_o     <= exe_pc_i;
                upd_taken_o  <= exe_taken_i;
                upd_target_o <= exe_target_i;
            end
            if (resolve & mis) begin
                redirect_pc_o <= redirect;
            end
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end
            if (recover) begin
                rd_ptr_q <= wr_ptr_q;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

`ifdef BPU_RESOLVE_STATS_EN
    // Wrapping event counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_resolved_o    <= '0;
            stat_mispredict_o  <= '0;
            stat_unpredicted_o <= '0;
        end else begin
            if (resolve) begin
                stat_resolved_o <= stat_resolved_o + 32'd1;
            end
            if (mispredict_o) begin
                stat_mispredict_o <= stat_mispredict_o + 32'd1;
            end
            if (resolve & ~hit) begin
                stat_unpredicted_o <= stat_unpredicted_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bpu_resolve_queue.sv
// Directed table-driven bench for bpu_resolve_queue (DEPTH=4, XLEN=32).
module tb_bpu_resolve_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, pred_valid_i, exe_is_branch_i, exe_taken_i;
    logic [31:0] pred_pc_i, pred_target_i, exe_pc_i, exe_target_i;
    logic        full_o, mispredict_o, upd_valid_o, upd_taken_o, overflow_o;
    logic [31:0] redirect_pc_o, upd_pc_o, upd_target_o;
`ifdef BPU_RESOLVE_STATS_EN
    logic [31:0] stat_resolved_o, stat_mispredict_o, stat_unpredicted_o;
`endif

    int checks = 0;
    int errors = 0;

    bpu_resolve_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .pred_target_i(pred_target_i),
        .exe_is_branch_i(exe_is_branch_i), .exe_pc_i(exe_pc_i), .exe_taken_i(exe_taken_i),
        .exe_target_i(exe_target_i), .full_o(full_o), .mispredict_o(mispredict_o),
        .redirect_pc_o(redirect_pc_o), .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o),
        .upd_taken_o(upd_taken_o), .upd_target_o(upd_target_o),
`ifdef BPU_RESOLVE_STATS_EN
        .stat_resolved_o(stat_resolved_o), .stat_mispredict_o(stat_mispredict_o),
        .stat_unpredicted_o(stat_unpredicted_o),
`endif
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        st, fl, pv;
        logic [31:0] ppc, ptg;
        logic        br;
        logic [31:0] epc;
        logic        tk;
        logic [31:0] etg;
        logic        full, mis;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        utk;
        logic [31:0] utg;
        logic        ovf;
    } vec_t;

    function automatic vec_t mk(string n, logic st, logic fl, logic pv, logic [31:0] ppc,
                                logic [31:0] ptg, logic br, logic [31:0] epc, logic tk,
                                logic [31:0] etg, logic full, logic mis, logic [31:0] rpc,
                                logic uv, logic [31:0] upc, logic utk, logic [31:0] utg,
                                logic ovf);
        vec_t v;
        v.name = n; v.st = st; v.fl = fl; v.pv = pv; v.ppc = ppc; v.ptg = ptg;
        v.br = br; v.epc = epc; v.tk = tk; v.etg = etg; v.full = full; v.mis = mis;
        v.rpc = rpc; v.uv = uv; v.upc = upc; v.utk = utk; v.utg = utg; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall_i = v.st; flush_i = v.fl; pred_valid_i = v.pv;
        pred_pc_i = v.ppc; pred_target_i = v.ptg;
        exe_is_branch_i = v.br; exe_pc_i = v.epc; exe_taken_i = v.tk; exe_target_i = v.etg;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk_i);
        drive(v);
        @(posedge clk_i);
        #1;
        chk({v.name, ".full"}, 32'(full_o), 32'(v.full));
        chk({v.name, ".mis"}, 32'(mispredict_o), 32'(v.mis));
        chk({v.name, ".rpc"}, redirect_pc_o, v.rpc);
        chk({v.name, ".uv"}, 32'(upd_valid_o), 32'(v.uv));
        chk({v.name, ".upc"}, upd_pc_o, v.upc);
        chk({v.name, ".utk"}, 32'(upd_taken_o), 32'(v.utk));
        chk({v.name, ".utg"}, upd_target_o, v.utg);
        chk({v.name, ".ovf"}, 32'(overflow_o), 32'(v.ovf));
    endtask

    vec_t vecs[37];
    vec_t idle;

    initial begin
        idle = mk("idle", 0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0,0,0);
        //          name          st fl pv ppc  ptg      br epc  tk etg     full mis rpc uv upc utk utg ovf
        vecs[0]  = mk("t1_push",  0,0,1, 'h100,'h200, 0,0,0,0,             0,0,0,0,0,0,0,0);
        vecs[1]  = mk("t1_hit",   0,0,0, 0,0, 1,'h100,1,'h200,             0,0,0,1,'h100,1,'h200,0);
        vecs[2]  = mk("t1_idle",  0,0,0, 0,0, 0,0,0,0,                     0,0,0,0,'h100,1,'h200,0);
        vecs[3]  = mk("t2_push",  0,0,1, 'h100,'h200, 0,0,0,0,             0,0,0,0,'h100,1,'h200,0);
        vecs[4]  = mk("t2_nt",    0,0,0, 0,0, 1,'h100,0,0,                 0,1,'h104,1,'h100,0,0,0);
        vecs[5]  = mk("t2_idle",  0,0,0, 0,0, 0,0,0,0,                     0,0,'h104,0,'h100,0,0,0);
        vecs[6]  = mk("t3_empty", 0,0,0, 0,0, 1,'h300,1,'h380,             0,1,'h380,1,'h300,1,'h380,0);
        vecs[7]  = mk("t3_idle",  0,0,0, 0,0, 0,0,0,0,                     0,0,'h380,0,'h300,1,'h380,0);
        vecs[8]  = mk("t4_push0", 0,0,1, 'h400,'h500, 0,0,0,0,             0,0,'h380,0,'h300,1,'h380,0);
        vecs[9]  = mk("t4_push1", 0,0,1, 'h404,'h504, 0,0,0,0,             0,0,'h380,0,'h300,1,'h380,0);
        vecs[10] = mk("t4_push2", 0,0,1, 'h408,'h508, 0,0,0,0,             0,0,'h380,0,'h300,1,'h380,0);
        vecs[11] = mk("t4_push3", 0,0,1, 'h40c,'h50c, 0,0,0,0,             1,0,'h380,0,'h300,1,'h380,0);
        vecs[12] = mk("t4_ovf",   0,0,1, 'h410,'h510, 0,0,0,0,             1,0,'h380,0,'h300,1,'h380,1);
        vecs[13] = mk("t4_pushpop",0,0,1,'h414,'h514, 1,'h400,1,'h500,     1,0,'h380,1,'h400,1,'h500,1);
        vecs[14] = mk("t4_pop404",0,0,0, 0,0, 1,'h404,1,'h504,             0,0,'h380,1,'h404,1,'h504,1);
        vecs[15] = mk("t4_pop408",0,0,0, 0,0, 1,'h408,1,'h508,             0,0,'h380,1,'h408,1,'h508,1);
        vecs[16] = mk("t4_pop40c",0,0,0, 0,0, 1,'h40c,1,'h50c,             0,0,'h380,1,'h40c,1,'h50c,1);
        vecs[17] = mk("t4_pop414",0,0,0, 0,0, 1,'h414,1,'h514,             0,0,'h380,1,'h414,1,'h514,1);
        vecs[18] = mk("t4_drop410",0,0,0,0,0, 1,'h410,1,'h510,             0,1,'h510,1,'h410,1,'h510,1);
        vecs[19] = mk("t4_idle",  0,0,0, 0,0, 0,0,0,0,                     0,0,'h510,0,'h410,1,'h510,1);
        vecs[20] = mk("t5_push0", 0,0,1, 'h600,'h200, 0,0,0,0,             0,0,'h510,0,'h410,1,'h510,1);
        vecs[21] = mk("t5_push1", 0,0,1, 'h604,'h204, 0,0,0,0,             0,0,'h510,0,'h410,1,'h510,1);
        vecs[22] = mk("t5_push2", 0,0,1, 'h608,'h208, 0,0,0,0,             0,0,'h510,0,'h410,1,'h510,1);
        vecs[23] = mk("t5_tgtmis",0,0,0, 0,0, 1,'h600,1,'h240,             0,1,'h240,1,'h600,1,'h240,1);
        vecs[24] = mk("t5_pushdisc",0,0,1,'h700,'h800, 0,0,0,0,            0,0,'h240,0,'h600,1,'h240,1);
        vecs[25] = mk("t5_empty", 0,0,0, 0,0, 1,'h604,1,'h204,             0,1,'h204,1,'h604,1,'h204,1);
        vecs[26] = mk("t5_idle",  0,0,0, 0,0, 0,0,0,0,                     0,0,'h204,0,'h604,1,'h204,1);
        vecs[27] = mk("t5_nopush",0,0,0, 0,0, 1,'h700,1,'h800,             0,1,'h800,1,'h700,1,'h800,1);
        vecs[28] = mk("t5_idle2", 0,0,0, 0,0, 0,0,0,0,                     0,0,'h800,0,'h700,1,'h800,1);
        vecs[29] = mk("st_push",  1,0,1, 'h900,'h980, 0,0,0,0,             0,0,'h800,0,'h700,1,'h800,1);
        vecs[30] = mk("st_res",   1,0,0, 0,0, 1,'h900,1,'h980,             0,0,'h800,0,'h700,1,'h800,1);
        vecs[31] = mk("st_after", 0,0,0, 0,0, 1,'h900,1,'h980,             0,1,'h980,1,'h900,1,'h980,1);
        vecs[32] = mk("st_idle",  0,0,0, 0,0, 0,0,0,0,                     0,0,'h980,0,'h900,1,'h980,1);
        vecs[33] = mk("nt_ok",    0,0,0, 0,0, 1,'ha00,0,0,                 0,0,'h980,1,'ha00,0,0,1);
        vecs[34] = mk("wrap_push",0,0,1, 'hfffffffc,'h10, 0,0,0,0,         0,0,'h980,0,'ha00,0,0,1);
        vecs[35] = mk("wrap_nt",  0,0,0, 0,0, 1,'hfffffffc,0,0,            0,1,0,1,'hfffffffc,0,0,1);
        vecs[36] = mk("wrap_idle",0,0,0, 0,0, 0,0,0,0,                     0,0,0,0,'hfffffffc,0,0,1);

        drive(idle);
        rst_i = 1'b1;
        #12;
        chk("rst.full", 32'(full_o), 0);
        chk("rst.mis", 32'(mispredict_o), 0);
        chk("rst.uv", 32'(upd_valid_o), 0);
        chk("rst.ovf", 32'(overflow_o), 0);
        rst_i = 1'b0;

        for (int i = 0; i < 37; i++) run_vec(vecs[i]);

        // Async reset mid-cycle with two entries queued
        run_vec(mk("ar_push0", 0,0,1, 'hc00,'hc80, 0,0,0,0, 0,0,0,0,'hfffffffc,0,0,1));
        run_vec(mk("ar_push1", 0,0,1, 'hc04,'hc84, 0,0,0,0, 0,0,0,0,'hfffffffc,0,0,1));
        @(negedge clk_i);
        drive(idle);
        #2 rst_i = 1'b1;
        #1;
        chk("ar.full", 32'(full_o), 0);
        chk("ar.ovf", 32'(overflow_o), 0);
        chk("ar.upc", upd_pc_o, 0);
        chk("ar.uv", 32'(upd_valid_o), 0);
        #3 rst_i = 1'b0;
        run_vec(mk("ar_empty", 0,0,0, 0,0, 1,'hc00,1,'hc80, 0,1,'hc80,1,'hc00,1,'hc80,0));
        run_vec(mk("ar_idle",  0,0,0, 0,0, 0,0,0,0,         0,0,'hc80,0,'hc00,1,'hc80,0));

        // Flush beats push and pop and suppresses strobes
        run_vec(mk("fl_push", 0,0,1, 'hd00,'hd80, 0,0,0,0,       0,0,'hc80,0,'hc00,1,'hc80,0));
        run_vec(mk("fl_all",  0,1,1, 'hd04,'hd84, 1,'hd00,1,'hd80, 0,0,'hc80,0,'hc00,1,'hc80,0));
        run_vec(mk("fl_empty",0,0,0, 0,0, 1,'hd00,1,'hd80,       0,1,'hd80,1,'hd00,1,'hd80,0));
        run_vec(mk("fl_idle", 0,0,0, 0,0, 0,0,0,0,               0,0,'hd80,0,'hd00,1,'hd80,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
